// File: rtl/multi_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
// HALT exists only when MULTI_CTRL_ILLEGAL_TRAP_EN is defined.
package multi_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle shared by the control unit and its neighbours.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (input clk, input reset);
endinterface

// File: rtl/alu_decoder.sv
// Maps (aluop, funct) to the ALU control code; flags funct values the ALU cannot execute.
module alu_decoder
  import multi_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_ctrl    = ALU_ADD;
    o_funct_valid = 1'b1;
    case (i_aluop)
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_funct_valid = 1'b0;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_controller.sv
// Moore control FSM for the multi-cycle CPU datapath.
// Define MULTI_CTRL_ILLEGAL_TRAP_EN to trap unknown op/funct into a sticky HALT state.
module multi_controller
  import multi_ctrl_pkg::*;
(
  ctrl_bus_if.central ctrl_bus,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        i_or_d,
  output logic        ireg_write_enab,
  output logic        pc_write_enab,
  output logic        pc_src,
  output logic        jmp,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  alu_ctrl_sig,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_write,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_alu_en;
  logic [2:0] w_alu_ctrl;
  logic       w_funct_valid;

  alu_decoder u_alu_decoder (
    .i_aluop       (w_aluop),
    .i_funct       (funct),
    .o_alu_ctrl    (w_alu_ctrl),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) r_state <= S_FETCH;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
          default:      w_next = S_HALT;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
      S_RTYPEEX: w_next = w_funct_valid ? S_RTYPEWB : S_HALT;
      S_HALT:    w_next = S_HALT;
`else
      S_RTYPEEX: w_next = S_RTYPEWB;
`endif
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    i_or_d          = 1'b0;
    ireg_write_enab = 1'b0;
    pc_write_enab   = 1'b0;
    pc_src          = 1'b0;
    jmp             = 1'b0;
    alu_srcA        = 1'b0;
    alu_srcB        = SRCB_RT;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    reg_write       = 1'b0;
    mem_write       = 1'b0;
    w_aluop         = ALUOP_ADD;
    w_alu_en        = 1'b0;
    case (r_state)
      S_FETCH: begin
        ireg_write_enab = 1'b1;
        pc_write_enab   = 1'b1;
        alu_srcB        = SRCB_FOUR;
        w_alu_en        = 1'b1;
      end
      S_DECODE: begin
        alu_srcB = SRCB_BROFF;
        w_alu_en = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
        w_alu_en = 1'b1;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_RTYPEEX: begin
        alu_srcA = 1'b1;
        w_aluop  = ALUOP_FUNCT;
        w_alu_en = 1'b1;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BEQEX: begin
        alu_srcA      = 1'b1;
        w_aluop       = ALUOP_SUB;
        w_alu_en      = 1'b1;
        pc_src        = 1'b1;
        pc_write_enab = zero;
      end
      S_JEX: begin
        jmp           = 1'b1;
        pc_write_enab = 1'b1;
      end
      default: ;
    endcase
    // Reset masks the enables immediately, before the state register has settled.
    if (ctrl_bus.reset) begin
      ireg_write_enab = 1'b0;
      pc_write_enab   = 1'b0;
      reg_write       = 1'b0;
      mem_write       = 1'b0;
    end
  end

  assign alu_ctrl_sig = w_alu_en ? w_alu_ctrl : '0;

`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_HALT);
`else
  logic w_unused_funct_valid;
  assign w_unused_funct_valid = w_funct_valid;
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/multi_controller.md
# multi_controller

Control unit for the multi-cycle CPU. A Moore FSM reads the opcode and funct fields of the instruction register and the ALU zero flag from the datapath. It sequences every datapath select and write enable across the fetch/decode/execute/memory/writeback steps, plus the memory write strobe. It sits directly upstream of the datapath and drives all of its control inputs.

## Interface
- No parameters.
- ctrl_bus.clk  input  1  clock, rising edge; reached through ctrl_bus (ctrl_bus_if.central)
- ctrl_bus.reset  input  1  reset, asynchronous, active-high; reached through ctrl_bus
- op  input  6  instruction bits [31:26]
- funct  input  6  instruction bits [5:0]
- zero  input  1  ALU zero flag, combinational from the datapath
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register
- ireg_write_enab  output  1  instruction register load
- pc_write_enab  output  1  PC load
- pc_src  output  1  0 = sequential next PC, 1 = branch target
- jmp  output  1  1 = jump target
- alu_srcA  output  1  0 = PC, 1 = register operand path
- alu_srcB  output  2  00 = rt operand, 01 = constant 4, 10 = sign-extended immediate, 11 = branch offset
- alu_ctrl_sig  output  3  ALU operation
- reg_dst  output  1  0 = rt field, 1 = rd field
- mem_to_reg  output  1  0 = ALU result register, 1 = memory data register
- reg_write  output  1  register file write
- mem_write  output  1  data memory write strobe
- illegal  output  1  sticky unsupported-instruction flag; see Configuration

## Operation
- States and transitions:
  - FETCH → DECODE.
  - DECODE branches on op:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100 → BEQEX
    - addi 001000 → ADDIEX
    - j 000010 → JEX
    - any other op → FETCH, or HALT when the trap feature is compiled in
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - RTYPEEX → RTYPEWB → FETCH.
  - ADDIEX → ADDIWB → FETCH.
  - BEQEX → FETCH; JEX → FETCH.
- Asserted outputs per state; every output not listed is 0:
  - FETCH: ireg_write_enab=1, pc_write_enab=1, alu_srcB=01, alu add.
  - DECODE: alu_srcB=11, alu add (precomputes the branch target).
  - MEMADR / ADDIEX: alu_srcA=1, alu_srcB=10, add.
  - MEMRD: i_or_d=1.
  - MEMWR: i_or_d=1, mem_write=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - RTYPEEX: alu_srcA=1, alu_srcB=00, alu op from funct.
  - RTYPEWB: reg_write=1, reg_dst=1.
  - ADDIWB: reg_write=1.
  - BEQEX: alu_srcA=1, alu_srcB=00, sub, pc_src=1, pc_write_enab=zero.
  - JEX: jmp=1, pc_write_enab=1.
- ALU encoding:
  - add = 010, sub = 110, and = 000, or = 001, slt = 111.
  - funct mapping: 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - An unknown funct in RTYPEEX drives add; the writeback still occurs unless the instruction is trapped.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

## Timing
- State register updates on the rising edge of ctrl_bus.clk.
- All outputs are combinational from state. The only exception is pc_write_enab in BEQEX, which also depends on zero in the same cycle.
- Reset:
  - Asynchronous assertion forces the state to FETCH and clears illegal.
  - While reset is high, pc_write_enab, ireg_write_enab, reg_write and mem_write are forced to 0.
  - The first cycle after deassertion is FETCH with its normal outputs.
- Reset asserted mid-instruction abandons that instruction; no further write enable is issued for it.
- The op/funct values sampled in DECODE and RTYPEEX are those held in the instruction register. That register is stable outside FETCH.

## Configuration
- Macro: MULTI_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE, or an unknown funct in RTYPEEX, moves to HALT.
  - In the RTYPEEX case the writeback is skipped.
  - HALT sets illegal=1, keeps every write enable at 0, and is left only by reset.
- Undefined:
  - Unknown op returns DECODE → FETCH, so the instruction acts as a NOP.
  - Unknown funct executes as add.
  - There is no HALT state and illegal is tied to 0.

## Structure
- Package multi_ctrl_pkg holds:
  - the state enum;
  - opcode and funct localparams;
  - ALU op localparams;
  - the alu_srcB select localparams.
- Sub-module alu_decoder: combinational mapping of (aluop[1:0], funct) to alu_ctrl_sig and funct_valid.
  - aluop 00 = add, 01 = sub, 10 = use funct.

## Test plan
- Reset mid-MEMWR, then release → mem_write drops to 0 immediately; the first post-reset cycle is FETCH with ireg_write_enab=1 and pc_write_enab=1.
- op=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB over exactly 5 cycles; MEMRD has i_or_d=1; MEMWB has reg_write=1, mem_to_reg=1.
- op=000000, funct=101010 → in RTYPEEX, alu_ctrl_sig=111; next cycle reg_write=1, reg_dst=1; total 4 cycles.
- op=000100 → in BEQEX with zero=1, pc_write_enab=1 and pc_src=1; with zero=0, pc_write_enab=0; both cases take 3 cycles.
- op=000010 → JEX asserts jmp=1 and pc_write_enab=1, then FETCH.
- op=111111 → with the macro defined, HALT is entered and illegal=1 stays set across 10 cycles until reset; without the macro, the FSM returns to FETCH after 2 cycles with illegal=0.
